// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM multi-port arbiter.
//   - Command and size encodings understood by the QSPI PSRAM controller.
//   - Arbiter FSM state codes.
//   - cmd_t bundles one registered command as presented to the controller.
//   - is_cmd() marks a port request that should take part in arbitration.
package psram_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_WORD  = 2'd1;
    localparam logic [1:0] SZ_DWORD = 2'd2;

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    typedef struct packed {
        logic [1:0]  req;
        logic [1:0]  size;
        logic [23:0] addr;
        logic [31:0] din;
    } cmd_t;

    // 2'b11 is deliberately not a command: it is treated as a nop.
    function automatic logic is_cmd(input logic [1:0] r);
        return (r == CMD_WRITE) || (r == CMD_READ);
    endfunction

endpackage

// File: rtl/psram_rr_pick.sv
// Combinational round-robin picker over ports 1..NPORT-1 (port 0 is ignored; it is
// handled by the fixed-priority path in the arbiter).
// Ports:
//   req  in  NPORT  per-port request flags
//   ptr  in  IW     port to search from (always in 1..NPORT-1)
//   gnt  out NPORT  one-hot grant (all zero when nobody in 1..NPORT-1 requests)
//   idx  out IW     index of the granted port (0 when nothing granted)
module psram_rr_pick #(
    parameter int unsigned NPORT = 3,
    parameter int unsigned IW    = 2
) (
    input  logic [NPORT-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [NPORT-1:0] gnt,
    output logic [IW-1:0]    idx
);

    int unsigned cand;
    logic        found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < NPORT - 1; k++) begin
            // Wrap NPORT-1 -> 1, never onto port 0.
            cand = int'(ptr) + k;
            if (cand > NPORT - 1) begin
                cand = cand - (NPORT - 1);
            end
            if (!found && req[cand[IW-1:0]]) begin
                found               = 1'b1;
                gnt[cand[IW-1:0]]   = 1'b1;
                idx                 = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/psram_arb.sv
// Multi-port arbiter in front of one QSPI PSRAM controller.
// Grants one command at a time, holds it on the cmd bus until cmd_ack, then routes the
// read data strobes to the port that owns the last accepted read.
// Port 0 has fixed priority but yields after HP_MAX consecutive grants while any other
// port waits; ports 1..NPORT-1 share round-robin.
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   p_req/p_size/p_addr/p_din      packed per-port command fields (port i at slice i)
//   p_ack                          one-cycle accept pulse to the owning port
//   p_valid                        read data strobe to the owner of the last accepted read
//   rd_data                        controller read data, passed through ungated
//   cmd_req/size/addr/din          registered command towards the controller
//   cmd_ack, cmd_dout, data_valid  controller handshake and read data
//   err_tmo                        sticky: a command waited ACK_TMO cycles for its ack
module psram_arb
    import psram_pkg::*;
#(
    parameter int unsigned NPORT   = 3,
    parameter int unsigned HP_MAX  = 4,
    parameter int unsigned ACK_TMO = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2*NPORT-1:0]  p_req,
    input  logic [2*NPORT-1:0]  p_size,
    input  logic [24*NPORT-1:0] p_addr,
    input  logic [32*NPORT-1:0] p_din,
    output logic [NPORT-1:0]    p_ack,
    output logic [NPORT-1:0]    p_valid,
    output logic [31:0]         rd_data,
    output logic [1:0]          cmd_req,
    output logic [1:0]          cmd_size,
    output logic [23:0]         cmd_addr,
    output logic [31:0]         cmd_din,
    input  logic                cmd_ack,
    input  logic [31:0]         cmd_dout,
    input  logic                data_valid,
    output logic                err_tmo
);

    localparam int unsigned IW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int unsigned HW = $clog2(HP_MAX + 1);

    cmd_t             port_cmd [NPORT];
    logic [NPORT-1:0] port_valid;
    logic [NPORT-1:0] rr_gnt;
    logic [IW-1:0]    rr_idx;

    logic [0:0]       state;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    rd_owner;
    logic [HW-1:0]    hp_cnt;
    logic [IW-1:0]    rr_ptr;
    logic [7:0]       tmo_cnt;

    logic             others_req;
    logic             p0_win;
    logic [IW-1:0]    win;
    logic [7:0]       tmo_nxt;

    for (genvar g = 0; g < NPORT; g++) begin : g_port
        assign port_cmd[g].req  = p_req[2*g +: 2];
        assign port_cmd[g].size = p_size[2*g +: 2];
        assign port_cmd[g].addr = p_addr[24*g +: 24];
        assign port_cmd[g].din  = p_din[32*g +: 32];
        assign port_valid[g]    = is_cmd(port_cmd[g].req);
        // rd_owner is only updated by an accepted read, so later writes never steal data.
        assign p_valid[g]       = data_valid && (rd_owner == IW'(g));
    end

    psram_rr_pick #(
        .NPORT (NPORT),
        .IW    (IW)
    ) u_rr_pick (
        .req (port_valid),
        .ptr (rr_ptr),
        .gnt (rr_gnt),
        .idx (rr_idx)
    );

    assign others_req = |rr_gnt;
    assign p0_win     = port_valid[0] && ((hp_cnt < HW'(HP_MAX)) || !others_req);
    assign win        = p0_win ? '0 : rr_idx;
    assign tmo_nxt    = (tmo_cnt == 8'hFF) ? tmo_cnt : tmo_cnt + 8'd1;
    assign rd_data    = cmd_dout;

    always_comb begin
        p_ack = '0;
        if (state == ST_ISSUE && cmd_ack) begin
            p_ack[owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_ARB;
            cmd_req  <= CMD_IDLE;
            cmd_size <= SZ_BYTE;
            cmd_addr <= '0;
            cmd_din  <= '0;
            err_tmo  <= 1'b0;
            owner    <= '0;
            rd_owner <= '0;
            hp_cnt   <= '0;
            rr_ptr   <= IW'(1);
            tmo_cnt  <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (|port_valid) begin
                        cmd_req  <= port_cmd[win].req;
                        cmd_size <= port_cmd[win].size;
                        cmd_addr <= port_cmd[win].addr;
                        cmd_din  <= port_cmd[win].din;
                        owner    <= win;
                        tmo_cnt  <= '0;
                        state    <= ST_ISSUE;
                        if (p0_win) begin
                            if (hp_cnt < HW'(HP_MAX)) begin
                                hp_cnt <= hp_cnt + HW'(1);
                            end
                        end else begin
                            hp_cnt <= '0;
                            rr_ptr <= (win == IW'(NPORT - 1)) ? IW'(1) : win + IW'(1);
                        end
                    end
                end
                default: begin
                    if (cmd_ack) begin
                        cmd_req <= CMD_IDLE;
                        if (cmd_req == CMD_READ) begin
                            rd_owner <= owner;
                        end
                        state <= ST_ARB;
                    end else begin
                        // No abort on timeout: flag it and keep waiting for a late ack.
                        tmo_cnt <= tmo_nxt;
                        if (tmo_nxt == 8'(ACK_TMO)) begin
                            err_tmo <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psram_arb.sv
// Self-checking bench for psram_arb (NPORT=3, HP_MAX=4, ACK_TMO=255).
// A controller model acks 2 cycles after cmd_req and returns two data pulses per read.
// Expected accepts / data strobes are queued per test and compared with observed events.
module tb_psram_arb;
    import psram_pkg::*;

    localparam int NP = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [2*NP-1:0]    p_req = '0;
    logic [2*NP-1:0]    p_size = '0;
    logic [24*NP-1:0]   p_addr = '0;
    logic [32*NP-1:0]   p_din = '0;
    logic [NP-1:0]      p_ack;
    logic [NP-1:0]      p_valid;
    logic [31:0]        rd_data;
    logic [1:0]         cmd_req;
    logic [1:0]         cmd_size;
    logic [23:0]        cmd_addr;
    logic [31:0]        cmd_din;
    logic               cmd_ack = 1'b0;
    logic [31:0]        cmd_dout = 32'h0;
    logic               data_valid = 1'b0;
    logic               err_tmo;

    psram_arb #(
        .NPORT   (3),
        .HP_MAX  (4),
        .ACK_TMO (255)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .p_req      (p_req),
        .p_size     (p_size),
        .p_addr     (p_addr),
        .p_din      (p_din),
        .p_ack      (p_ack),
        .p_valid    (p_valid),
        .rd_data    (rd_data),
        .cmd_req    (cmd_req),
        .cmd_size   (cmd_size),
        .cmd_addr   (cmd_addr),
        .cmd_din    (cmd_din),
        .cmd_ack    (cmd_ack),
        .cmd_dout   (cmd_dout),
        .data_valid (data_valid),
        .err_tmo    (err_tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [1:0]  req;
        logic [1:0]  size;
        logic [23:0] addr;
        logic [31:0] din;
    } ack_t;

    typedef struct {
        logic [NP-1:0] vec;
        logic [31:0]   data;
    } val_t;

    ack_t exp_ack[$];
    ack_t obs_ack[$];
    val_t exp_val[$];
    val_t obs_val[$];

    int vectors = 0;
    int miscompares = 0;

    // Requesters: port i requests rq[i] while want[i] > 0; address steps by 4 per accept.
    int          want [NP];
    logic [1:0]  rq   [NP];
    logic [23:0] ad   [NP];
    bit          ackd [NP];

    // Controller model state.
    bit          ack_en = 1'b1;
    bit          spurious = 1'b0;
    int          cnt = 0;
    int          dv_left = 0;
    int          dv_wait = 0;
    int          dv_k = 0;
    logic [23:0] dv_addr = '0;

    function automatic ack_t mk_ack(int p, logic [1:0] r, logic [23:0] a);
        ack_t e;
        e.port = p;
        e.req  = r;
        e.size = 2'(p);
        e.addr = a;
        e.din  = {8'(p), a};
        return e;
    endfunction

    function automatic val_t mk_val(int p, logic [23:0] a, int k);
        val_t v;
        v.vec  = '0;
        v.vec[p] = 1'b1;
        v.data = {a, 8'(k)};
        return v;
    endfunction

    initial begin
        for (int i = 0; i < NP; i++) begin
            want[i] = 0;
            rq[i]   = CMD_IDLE;
            ad[i]   = '0;
            ackd[i] = 1'b0;
        end
    end

    // Inputs change on the falling edge; outputs are sampled 1 time unit before the rise.
    always @(negedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (ackd[i]) begin
                ackd[i] = 1'b0;
                if (want[i] > 0) want[i] = want[i] - 1;
                ad[i] = ad[i] + 24'd4;
            end
            p_req[2*i +: 2]   = (want[i] > 0) ? rq[i] : CMD_IDLE;
            p_size[2*i +: 2]  = 2'(i);
            p_addr[24*i +: 24] = ad[i];
            p_din[32*i +: 32] = {8'(i), ad[i]};
        end
        cmd_ack    = 1'b0;
        data_valid = 1'b0;
        if (!reset) begin
            cnt     = 0;
            dv_left = 0;
        end else if (spurious) begin
            cmd_ack  = 1'b1;
            spurious = 1'b0;
        end else if (dv_left > 0) begin
            if (dv_wait > 0) begin
                dv_wait = dv_wait - 1;
            end else begin
                data_valid = 1'b1;
                cmd_dout   = {dv_addr, 8'(dv_k)};
                dv_k       = dv_k + 1;
                dv_left    = dv_left - 1;
            end
        end else if ((cmd_req == CMD_WRITE || cmd_req == CMD_READ) && ack_en) begin
            cnt = cnt + 1;
            if (cnt >= 2) begin
                cmd_ack = 1'b1;
                cnt     = 0;
                if (cmd_req == CMD_READ) begin
                    dv_left = 2;
                    dv_wait = 2;
                    dv_k    = 0;
                    dv_addr = cmd_addr;
                end
            end
        end else begin
            cnt = 0;
        end
        #4;
        if (reset) begin
            if (p_ack != '0) begin
                ack_t o;
                o.port = -1;
                if ($onehot(p_ack)) begin
                    for (int i = 0; i < NP; i++) if (p_ack[i]) o.port = i;
                end
                o.req  = cmd_req;
                o.size = cmd_size;
                o.addr = cmd_addr;
                o.din  = cmd_din;
                obs_ack.push_back(o);
                for (int i = 0; i < NP; i++) if (p_ack[i]) ackd[i] = 1'b1;
            end
            if (data_valid || p_valid != '0) begin
                val_t v;
                v.vec  = p_valid;
                v.data = rd_data;
                obs_val.push_back(v);
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        for (int i = 0; i < NP; i++) begin
            want[i] = 0;
            ackd[i] = 1'b0;
        end
        ack_en   = 1'b1;
        spurious = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        exp_ack.delete();
        obs_ack.delete();
        exp_val.delete();
        obs_val.delete();
        reset = 1'b1;
    endtask

    // Bounded wait until all requests are accepted and all read data delivered.
    task automatic wait_idle(input string name, input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (want[0] == 0 && want[1] == 0 && want[2] == 0 && cmd_req == CMD_IDLE &&
                dv_left == 0) begin
                done = 1'b1;
                break;
            end
        end
        repeat (2) @(posedge clk);
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s idle: traffic still pending after %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        vectors++;
        if ({cmd_req, cmd_size} !== 4'h0 || cmd_addr !== 24'h0 || cmd_din !== 32'h0) begin
            miscompares++;
            $display("FAIL reset cmd: got req %0d size %0d addr %h din %h, want all 0",
                     cmd_req, cmd_size, cmd_addr, cmd_din);
        end
        vectors++;
        if (p_ack !== 3'b000 || p_valid !== 3'b000 || err_tmo !== 1'b0) begin
            miscompares++;
            $display("FAIL reset out: got p_ack %b p_valid %b err %b, want 000 000 0",
                     p_ack, p_valid, err_tmo);
        end
        // Stray ack while idle must not reach any port.
        @(posedge clk);
        #2;
        spurious = 1'b1;
        repeat (4) @(posedge clk);
        vectors++;
        if (obs_ack.size() != 0) begin
            miscompares++;
            $display("FAIL arb_ack: got %0d p_ack pulses, want 0", obs_ack.size());
        end
    endtask

    task automatic test_single_read();
        ack_t e, o;
        val_t ev, ov;
        apply_reset();
        rq[2] = CMD_READ;
        ad[2] = 24'h000100;
        exp_ack.push_back(mk_ack(2, CMD_READ, 24'h000100));
        exp_val.push_back(mk_val(2, 24'h000100, 0));
        exp_val.push_back(mk_val(2, 24'h000100, 1));
        want[2] = 1;
        wait_idle("single_read", 50);
        while (exp_ack.size() > 0) begin
            e = exp_ack.pop_front();
            vectors++;
            if (obs_ack.size() == 0) begin
                miscompares++;
                $display("FAIL single_read ack: got none, want p%0d %h", e.port, e.addr);
            end else begin
                o = obs_ack.pop_front();
                if (o.port !== e.port || o.req !== e.req || o.size !== e.size ||
                    o.addr !== e.addr || o.din !== e.din) begin
                    miscompares++;
                    $display("FAIL single_read ack: got p%0d r%0d s%0d %h %h, want p%0d r%0d s%0d %h %h",
                             o.port, o.req, o.size, o.addr, o.din,
                             e.port, e.req, e.size, e.addr, e.din);
                end
            end
        end
        while (exp_val.size() > 0) begin
            ev = exp_val.pop_front();
            vectors++;
            if (obs_val.size() == 0) begin
                miscompares++;
                $display("FAIL single_read data: got none, want %b %h", ev.vec, ev.data);
            end else begin
                ov = obs_val.pop_front();
                if (ov.vec !== ev.vec || ov.data !== ev.data) begin
                    miscompares++;
                    $display("FAIL single_read data: got %b %h, want %b %h",
                             ov.vec, ov.data, ev.vec, ev.data);
                end
            end
        end
        vectors++;
        if (obs_ack.size() != 0 || obs_val.size() != 0) begin
            miscompares++;
            $display("FAIL single_read extra: got %0d acks %0d strobes, want 0 0",
                     obs_ack.size(), obs_val.size());
        end
    endtask

    task automatic test_rr_alternate();
        ack_t e, o;
        apply_reset();
        rq[1] = CMD_WRITE;
        rq[2] = CMD_WRITE;
        ad[1] = 24'h001000;
        ad[2] = 24'h002000;
        exp_ack.push_back(mk_ack(1, CMD_WRITE, 24'h001000));
        exp_ack.push_back(mk_ack(2, CMD_WRITE, 24'h002000));
        exp_ack.push_back(mk_ack(1, CMD_WRITE, 24'h001004));
        exp_ack.push_back(mk_ack(2, CMD_WRITE, 24'h002004));
        want[1] = 2;
        want[2] = 2;
        wait_idle("rr_alternate", 80);
        while (exp_ack.size() > 0) begin
            e = exp_ack.pop_front();
            vectors++;
            if (obs_ack.size() == 0) begin
                miscompares++;
                $display("FAIL rr_alternate ack: got none, want p%0d %h", e.port, e.addr);
            end else begin
                o = obs_ack.pop_front();
                if (o.port !== e.port || o.req !== e.req || o.size !== e.size ||
                    o.addr !== e.addr || o.din !== e.din) begin
                    miscompares++;
                    $display("FAIL rr_alternate ack: got p%0d r%0d %h %h, want p%0d r%0d %h %h",
                             o.port, o.req, o.addr, o.din, e.port, e.req, e.addr, e.din);
                end
            end
        end
        vectors++;
        if (obs_ack.size() != 0) begin
            miscompares++;
            $display("FAIL rr_alternate extra: got %0d acks, want 0", obs_ack.size());
        end
    endtask

    task automatic test_hp_fairness();
        ack_t e, o;
        int order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int n0 = 0;
        int n1 = 0;
        apply_reset();
        rq[0] = CMD_WRITE;
        rq[1] = CMD_WRITE;
        ad[0] = 24'h003000;
        ad[1] = 24'h004000;
        for (int k = 0; k < 10; k++) begin
            if (order[k] == 0) begin
                exp_ack.push_back(mk_ack(0, CMD_WRITE, 24'h003000 + 24'(4 * n0)));
                n0++;
            end else begin
                exp_ack.push_back(mk_ack(1, CMD_WRITE, 24'h004000 + 24'(4 * n1)));
                n1++;
            end
        end
        want[0] = 8;
        want[1] = 2;
        wait_idle("hp_fairness", 150);
        for (int k = 0; exp_ack.size() > 0; k++) begin
            e = exp_ack.pop_front();
            vectors++;
            if (obs_ack.size() == 0) begin
                miscompares++;
                $display("FAIL hp_fairness grant %0d: got none, want p%0d", k, e.port);
            end else begin
                o = obs_ack.pop_front();
                if (o.port !== e.port || o.req !== e.req || o.size !== e.size ||
                    o.addr !== e.addr || o.din !== e.din) begin
                    miscompares++;
                    $display("FAIL hp_fairness grant %0d: got p%0d %h, want p%0d %h",
                             k, o.port, o.addr, e.port, e.addr);
                end
            end
        end
        vectors++;
        if (obs_ack.size() != 0) begin
            miscompares++;
            $display("FAIL hp_fairness extra: got %0d acks, want 0", obs_ack.size());
        end
    endtask

    task automatic test_read_route();
        ack_t e, o;
        val_t ev, ov;
        apply_reset();
        rq[0] = CMD_READ;
        rq[1] = CMD_WRITE;
        ad[0] = 24'h005000;
        ad[1] = 24'h006000;
        exp_ack.push_back(mk_ack(0, CMD_READ, 24'h005000));
        exp_ack.push_back(mk_ack(1, CMD_WRITE, 24'h006000));
        exp_val.push_back(mk_val(0, 24'h005000, 0));
        exp_val.push_back(mk_val(0, 24'h005000, 1));
        want[0] = 1;
        want[1] = 1;
        wait_idle("read_route", 60);
        while (exp_ack.size() > 0) begin
            e = exp_ack.pop_front();
            vectors++;
            if (obs_ack.size() == 0) begin
                miscompares++;
                $display("FAIL read_route ack: got none, want p%0d %h", e.port, e.addr);
            end else begin
                o = obs_ack.pop_front();
                if (o.port !== e.port || o.req !== e.req || o.addr !== e.addr ||
                    o.din !== e.din) begin
                    miscompares++;
                    $display("FAIL read_route ack: got p%0d r%0d %h, want p%0d r%0d %h",
                             o.port, o.req, o.addr, e.port, e.req, e.addr);
                end
            end
        end
        while (exp_val.size() > 0) begin
            ev = exp_val.pop_front();
            vectors++;
            if (obs_val.size() == 0) begin
                miscompares++;
                $display("FAIL read_route data: got none, want %b %h", ev.vec, ev.data);
            end else begin
                ov = obs_val.pop_front();
                if (ov.vec !== ev.vec || ov.data !== ev.data) begin
                    miscompares++;
                    $display("FAIL read_route data: got %b %h, want %b %h",
                             ov.vec, ov.data, ev.vec, ev.data);
                end
            end
        end
        vectors++;
        if (obs_ack.size() != 0 || obs_val.size() != 0) begin
            miscompares++;
            $display("FAIL read_route extra: got %0d acks %0d strobes, want 0 0",
                     obs_ack.size(), obs_val.size());
        end
    endtask

    task automatic test_timeout();
        ack_t e, o;
        bit seen = 1'b0;
        apply_reset();
        ack_en = 1'b0;
        rq[1]  = CMD_WRITE;
        ad[1]  = 24'h007000;
        want[1] = 1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (cmd_req != CMD_IDLE) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL timeout issue: got cmd_req %0d, want nonzero within 20", cmd_req);
        end
        repeat (250) @(posedge clk);
        #1;
        vectors++;
        if (err_tmo !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout early: got err_tmo %b after 250 cycles, want 0", err_tmo);
        end
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (err_tmo !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout set: got err_tmo %b after 260 cycles, want 1", err_tmo);
        end
        exp_ack.push_back(mk_ack(1, CMD_WRITE, 24'h007000));
        ack_en = 1'b1;
        wait_idle("timeout", 30);
        vectors++;
        if (err_tmo !== 1'b1 || cmd_req !== CMD_IDLE) begin
            miscompares++;
            $display("FAIL timeout late_ack: got err %b cmd_req %0d, want 1 0", err_tmo, cmd_req);
        end
        while (exp_ack.size() > 0) begin
            e = exp_ack.pop_front();
            vectors++;
            if (obs_ack.size() == 0) begin
                miscompares++;
                $display("FAIL timeout ack: got none, want p%0d %h", e.port, e.addr);
            end else begin
                o = obs_ack.pop_front();
                if (o.port !== e.port || o.req !== e.req || o.addr !== e.addr) begin
                    miscompares++;
                    $display("FAIL timeout ack: got p%0d r%0d %h, want p%0d r%0d %h",
                             o.port, o.req, o.addr, e.port, e.req, e.addr);
                end
            end
        end
    endtask

    task automatic test_reset_mid_issue();
        ack_t e, o;
        apply_reset();
        ack_en = 1'b0;
        rq[2]  = CMD_READ;
        ad[2]  = 24'h008000;
        want[2] = 1;
        repeat (265) @(posedge clk);
        #1;
        vectors++;
        if (err_tmo !== 1'b1 || cmd_req !== CMD_READ) begin
            miscompares++;
            $display("FAIL mid_issue setup: got err %b cmd_req %0d, want 1 2", err_tmo, cmd_req);
        end
        #1;
        reset = 1'b0;
        want[2] = 0;
        #1;
        vectors++;
        if (cmd_req !== CMD_IDLE || p_ack !== 3'b000 || err_tmo !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_issue reset: got cmd_req %0d p_ack %b err %b, want 0 000 0",
                     cmd_req, p_ack, err_tmo);
        end
        apply_reset();
        rq[1] = CMD_WRITE;
        ad[1] = 24'h009000;
        exp_ack.push_back(mk_ack(1, CMD_WRITE, 24'h009000));
        want[1] = 1;
        wait_idle("mid_issue", 30);
        while (exp_ack.size() > 0) begin
            e = exp_ack.pop_front();
            vectors++;
            if (obs_ack.size() == 0) begin
                miscompares++;
                $display("FAIL mid_issue ack: got none, want p%0d %h", e.port, e.addr);
            end else begin
                o = obs_ack.pop_front();
                if (o.port !== e.port || o.req !== e.req || o.addr !== e.addr ||
                    o.din !== e.din) begin
                    miscompares++;
                    $display("FAIL mid_issue ack: got p%0d r%0d %h, want p%0d r%0d %h",
                             o.port, o.req, o.addr, e.port, e.req, e.addr);
                end
            end
        end
        vectors++;
        if (obs_ack.size() != 0 || err_tmo !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_issue extra: got %0d acks err %b, want 0 0",
                     obs_ack.size(), err_tmo);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rr_alternate();
        test_hp_fairness();
        test_read_route();
        test_timeout();
        test_reset_mid_issue();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
